// File: rtl/nibble_adder_pkg.sv
// Shared constants and state type for the nibble-serial add/subtract sequencer.
package nibble_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;
    // Wide enough to count up to 16 nibbles.
    localparam int unsigned IDX_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Host-side start/busy/done handshake and operand/result bus for the serial adder.
interface nibble_serial_adder_ctrl_if
    import nibble_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = NIBBLE_W * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry, overflow
    );

endinterface

// File: rtl/fourbit_adder.sv
// 4-bit ripple adder slice shared by the serial sequencer.
module fourbit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds or subtracts two 4*NIBBLES-bit operands one nibble per clock, LSB first,
// through a single shared fourbit_adder slice.
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    nibble_serial_adder_ctrl_if.slave  bus
);

    localparam int unsigned        W    = NIBBLE_W * NIBBLES;
    localparam logic [IDX_W-1:0]   LAST = IDX_W'(NIBBLES - 1);

    state_e               state_q, state_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic                 sub_q, sub_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 cy_q, cy_d;
    logic [W-1:0]         sum_q, sum_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;

    logic [NIBBLE_W-1:0]  slice_a, slice_b, slice_sum;
    logic                 slice_cout;

    // Select the active nibble; the b side is inverted for subtraction (a + ~b + 1).
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                slice_b = b_q[i*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
            end
        end
    end

    fourbit_adder u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (cy_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
                end
                cy_d  = slice_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    carry_d = slice_cout;
                    ovf_d   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                              (slice_sum[NIBBLE_W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    idx_d   = '0;
                    cy_d    = bus.sub;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for nibble_serial_adder_ctrl at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // sel picks which DUT the shared stimulus and observation refer to.
    logic        sel = 1'b0;
    logic        start_drv = 1'b0;
    logic        sub_drv = 1'b0;
    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;

    assign bus4.start = start_drv & ~sel;
    assign bus4.sub   = sub_drv;
    assign bus4.a     = a_drv;
    assign bus4.b     = b_drv;
    assign bus1.start = start_drv & sel;
    assign bus1.sub   = sub_drv;
    assign bus1.a     = a_drv[3:0];
    assign bus1.b     = b_drv[3:0];

    logic        cur_busy, cur_done, cur_carry, cur_ovf;
    logic [15:0] cur_sum;
    assign cur_busy  = sel ? bus1.busy : bus4.busy;
    assign cur_done  = sel ? bus1.done : bus4.done;
    assign cur_carry = sel ? bus1.carry : bus4.carry;
    assign cur_ovf   = sel ? bus1.overflow : bus4.overflow;
    assign cur_sum   = sel ? {12'h000, bus1.sum} : bus4.sum;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned sum for result/carry, signed integer arithmetic for overflow.
    function automatic void model(input int unsigned w, input logic [15:0] a,
                                  input logic [15:0] b, input logic sub,
                                  output logic [15:0] s, output logic c, output logic v);
        longint mask, ua, ub, full, half, sa, sb, r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = ua + ((sub ? ~ub : ub) & mask) + (sub ? 1 : 0);
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        r    = sub ? sa - sb : sa + sb;
        s    = 16'(full & mask);
        c    = ((full >> w) & 1) != 0;
        v    = (r >= half) || (r < -half);
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (chain) or one after.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] es, input logic ec,
                         input logic ev, input bit poke, input bit chain);
        int n;
        int lat;
        int bcnt;
        n    = sel ? 1 : 4;
        lat  = 0;
        bcnt = 0;
        a_drv = a; b_drv = b; sub_drv = sub; start_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        while (!cur_done && lat < 40) begin
            if (cur_busy) bcnt++;
            start_drv = poke && lat < 2;
            a_drv     = 16'($urandom);
            b_drv     = 16'($urandom);
            sub_drv   = ~sub_drv;
            @(negedge clk);
            lat++;
        end
        start_drv = 1'b0;
        check({tag, "/latency"}, lat, n);
        check({tag, "/busy_cycles"}, bcnt, n);
        check({tag, "/busy_at_done"}, cur_busy, 1'b0);
        check({tag, "/sum"}, cur_sum, es);
        check({tag, "/carry"}, cur_carry, ec);
        check({tag, "/overflow"}, cur_ovf, ev);
        if (!chain) begin
            @(negedge clk);
            check({tag, "/done_pulse"}, cur_done, 1'b0);
            check({tag, "/sum_held"}, cur_sum, es);
        end
    endtask

    task automatic rand_op(input string tag, input bit chain);
        logic [15:0] a, b, es;
        logic        sub, ec, ev;
        a   = 16'($urandom);
        b   = 16'($urandom);
        sub = 1'($urandom);
        model(sel ? 4 : 16, a, b, sub, es, ec, ev);
        do_op(tag, a, b, sub, es, ec, ev, 1'($urandom), chain);
    endtask

    initial begin
        #1;
        check("rst/busy4", bus4.busy, 1'b0);
        check("rst/done4", bus4.done, 1'b0);
        check("rst/sum4", bus4.sum, 16'h0000);
        check("rst/carry4", bus4.carry, 1'b0);
        check("rst/ovf4", bus4.overflow, 1'b0);
        check("rst/done1", bus1.done, 1'b0);
        check("rst/sum1", bus1.sum, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("start_in_run", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1);
        do_op("start_in_done", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort mid-operation with reset.
        a_drv = 16'hAAAA; b_drv = 16'h5555; sub_drv = 1'b0; start_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort/busy", cur_busy, 1'b0);
        check("abort/done", cur_done, 1'b0);
        check("abort/sum", cur_sum, 16'h0000);
        check("abort/carry", cur_carry, 1'b0);
        check("abort/ovf", cur_ovf, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort/no_done", cur_done, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort/idle_done", cur_done, 1'b0);
        do_op("after_abort", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++)
            rand_op($sformatf("rand16_%0d", i), (i < 24) && 1'($urandom));

        sel = 1'b1;
        @(negedge clk);
        do_op("n1_add", 16'h0009, 16'h0008, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("n1_poke", 16'h0003, 16'h0004, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++)
            rand_op($sformatf("rand4_%0d", i), (i < 14) && 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds or subtracts two wide operands (4*NIBBLES bits) using one shared fourbit_adder slice, one nibble per clock, LSB nibble first.
- Uses a start/busy/done handshake.
- Area-saving alternative to a full-width ripple chain. Sits between a host register file/FSM and the shared 4-bit adder datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; result valid
- sum  output  W  result; held until next accepted start
- carry  output  1  carry out of MSB nibble (for sub: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow of the W-bit result

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, sum=0, carry=0, overflow=0; internal operand regs, nibble index and carry reg all 0.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: index==NIBBLES-1 -> DONE, else stay.
  - DONE: start=1 -> RUN, else -> IDLE.
- Accept edge (start=1 in IDLE or DONE):
  - Latch a into a_reg, b into b_reg, sub into sub_reg.
  - index <= 0; carry_reg <= sub; busy <= 1; done <= 0.
  - Clear sum, carry and overflow to 0.
- RUN edge: the adder slice receives a_reg[4i+3:4i], b_reg[4i+3:4i] XOR {4{sub_reg}}, and carry_reg, where i = index.
  - sum[4i+3:4i] <= slice sum; carry_reg <= slice carry; index <= index+1.
- Last RUN edge (index==NIBBLES-1):
  - carry <= slice carry.
  - overflow <= (A_msb == B'_msb) && (S_msb != A_msb), where B' is the inverted b when sub_reg=1.
  - done <= 1; busy <= 0; state <= DONE.
- Latency: done is high exactly NIBBLES clocks after the accept edge. Back-to-back throughput is one result per NIBBLES+1 clocks.
- busy and done are never high together.
- start while in RUN is ignored: no relatch, and the operation in flight is unaffected.
- start in the DONE cycle is accepted: done drops the next cycle and busy rises.
- a, b and sub may change freely after the accept edge; only the latched copies are used.
- Width rules:
  - Result is W bits, modulo 2^W.
  - carry is the true carry out of bit W-1.
  - Subtraction is a + ~b + 1.
- NIBBLES=1: a single RUN cycle; done is high 1 clock after accept.
- rst_n asserted at any time, including mid-RUN: immediate return to reset values; no done pulse for the aborted operation.
- sum is stable and holds its last value in IDLE and DONE.
- sum is only partially valid while busy; the host must not use it before done.

Decomposition:
- Package nibble_adder_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - NIBBLE_W=4.
  - Index width constant IDX_W=4 (covers NIBBLES<=16).
- One sub-module instance: the existing fourbit_adder (4-bit ripple slice) as the shared datapath.
- Controller logic (FSM, index counter, operand and carry registers, result assembly, overflow flag) lives in nibble_serial_adder_ctrl.

Test Plan:
1. NIBBLES=4, a=16'h1234, b=16'h4321, sub=0 -> done 4 clocks after accept; sum=16'h5555, carry=0, overflow=0; busy high for exactly 4 cycles.
2. a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, carry=1, overflow=0. Then a=16'h7FFF, b=16'h0001 -> sum=16'h8000, carry=0, overflow=1.
3. sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, carry=0 (borrow), overflow=0. Then a=16'h8000, b=16'h0001 -> sum=16'h7FFF, carry=1, overflow=1.
4. Handshake edge cases:
   - start pulsed at cycles 1 and 2 of RUN with different operands -> ignored; first result unchanged.
   - start held high in the DONE cycle with a=16'h0001, b=16'h0002 -> next done gives sum=16'h0003, with no IDLE cycle in between.
5. rst_n pulled low after 2 RUN cycles of 16'hAAAA+16'h5555 -> all outputs 0 immediately and no done pulse. After release, a new start gives the correct 16'hFFFF, carry=0.
6. NIBBLES=1 build: a=4'h9, b=4'h8, sub=0 -> done 1 clock after accept; sum=4'h1, carry=1, overflow=1.
